// File: rtl/data_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_if
//  Description : Bridge between the memory-access stage's single-cycle
//                data-RAM port and the shared Wishbone-style system bus.
//                Each stage access becomes one registered bus transaction.
//                The pipeline is stalled until the slave acknowledges, and
//                the read word is then returned to the stage. A no-ack
//                timeout aborts transactions to dead slaves.
//
//  Ports       : clk, rst          - core clock, async active-high reset
//                stall_i, flush_i  - pipeline stall vector / flush
//                cpu_*_i           - stage access request (ce/we/addr/sel/data)
//                cpu_data_o        - load data back to the stage
//                stallreq_o        - stall request to the control unit
//                bus_err_o         - one-cycle pulse on bus timeout
//                wb_*_o / wb_*_i   - Wishbone master side
//
//  Revision    : 1.0 - initial release
// ============================================================================
module data_bus_if #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [5:0]  stall_i,
    input  logic        flush_i,

    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    // Timeout disabled when TIMEOUT_CYCLES is zero; the compare value is
    // then irrelevant, so it is pinned to zero to avoid a negative constant.
    localparam logic             c_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                             : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_rd_buf;
    logic [CNT_W-1:0]   r_to_cnt;

    logic w_start;      // new transaction launched from IDLE
    logic w_abort;      // flush while a transaction is on the bus
    logic w_ack;        // slave acknowledged (flush takes precedence)
    logic w_timeout;    // no ack within the allowed number of cycles
    logic w_end;        // transaction completed normally or timed out
    logic [31:0] w_rd_word;

    assign w_start   = (r_state == ST_IDLE) & cpu_ce_i & ~flush_i;
    assign w_abort   = (r_state == ST_BUSY) & flush_i;
    assign w_ack     = (r_state == ST_BUSY) & ~flush_i & wb_ack_i;
    assign w_timeout = (r_state == ST_BUSY) & ~flush_i & ~wb_ack_i
                       & c_TO_EN & (r_to_cnt == c_TO_LAST);
    assign w_end     = w_ack | w_timeout;

    // Stores return no data to the stage.
    assign w_rd_word = wb_we_o ? 32'd0 : wb_dat_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs to the stage
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        stallreq_o  = 1'b0;
        cpu_data_o  = 32'd0;

        case (r_state)
            ST_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (w_start) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (wb_ack_i) begin
                    cpu_data_o  = w_rd_word;
                    w_state_nxt = (|stall_i) ? ST_WAIT : ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = (|stall_i) ? ST_WAIT : ST_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            ST_WAIT: begin
                // Result is held until the rest of the pipeline releases.
                cpu_data_o = r_rd_buf;
                if (flush_i || (stall_i == 6'd0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (rst) begin
            stallreq_o = 1'b0;
            cpu_data_o = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Bus master registers, timeout counter, read buffer, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_adr_o  <= 32'd0;
            wb_dat_o  <= 32'd0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'd0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            r_rd_buf  <= 32'd0;
            r_to_cnt  <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= w_timeout;

            if (w_start) begin
                wb_adr_o <= cpu_addr_i;
                wb_dat_o <= cpu_data_i;
                wb_we_o  <= cpu_we_i;
                wb_sel_o <= cpu_sel_i;
                wb_stb_o <= 1'b1;
                wb_cyc_o <= 1'b1;
                r_to_cnt <= '0;
            end else if (w_abort || w_end) begin
                wb_adr_o <= 32'd0;
                wb_dat_o <= 32'd0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= 4'd0;
                wb_stb_o <= 1'b0;
                wb_cyc_o <= 1'b0;
            end else if (r_state == ST_BUSY) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_ack) begin
                r_rd_buf <= w_rd_word;
            end else if (w_abort || w_timeout) begin
                r_rd_buf <= 32'd0;
            end else if ((r_state == ST_WAIT) && flush_i) begin
                r_rd_buf <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire
